alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising edge), rst_n input 1 (synchronous, active-low).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the completed-operation counter.
REQ-003 req_valid input 2: per-port request valid, index 0 = port 0, index 1 = port 1.
REQ-004 req_ready output 2: per-port request accepted this cycle.
REQ-005 req_a0, req_b0, req_a1, req_b1 input 32 each: per-port operands.
REQ-006 req_op0, req_op1 input 4 each: per-port opcode.
REQ-007 rsp_valid output 2: per-port response valid.
REQ-008 rsp_ready input 2: per-port response consumed.
REQ-009 rsp_result output 32: result of the operation being returned.
REQ-010 rsp_n, rsp_z, rsp_v, rsp_c output 1 each: result flags.
REQ-011 rsp_err output 1: the returned opcode was illegal.
REQ-012 busy output 1: high in any state other than IDLE.
REQ-013 op_count output CNT_W: count of completed response handshakes.
REQ-014 err_count output 8: count of completed responses with rsp_err set.

Function
REQ-015 Opcodes SHALL be: ADD 0000, SUB 1000, SLL 0001, SLT 0010 (signed a<b), SLTU 0011 (unsigned a<b), XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111; any other value is illegal.
REQ-016 Shift amount SHALL be b[4:0]; SLT/SLTU results SHALL be 32'd1 or 32'd0.
REQ-017 Flags: n = result[31]; z = (result == 0); c = carry-out for ADD and NOT-borrow for SUB, 0 otherwise; v = signed overflow for ADD/SUB, 0 otherwise.
REQ-018 An illegal opcode SHALL give result 0, all flags 0, rsp_err 1; it is otherwise handled as a normal transaction.
REQ-019 The FSM SHALL have states IDLE, EXEC and RESP; only one transaction is outstanding at a time.
REQ-020 In IDLE, req_ready SHALL be asserted combinationally only for the granted port, and only if that port's req_valid is high.
REQ-021 Arbitration SHALL be round-robin: if both ports are valid, grant the port other than last_grant; if one port is valid, grant it.
REQ-022 On acceptance (req_valid & req_ready), the block SHALL latch operands, opcode and port index, update last_grant, and move IDLE->EXEC.
REQ-023 In EXEC, the ALU result and flags SHALL be registered into the response registers and the FSM SHALL move to RESP; this state always lasts exactly one cycle.
REQ-024 In RESP, rsp_valid SHALL be high only at the latched port index, with result, flags and err held stable until rsp_ready of that port is high.
REQ-025 On a response handshake, the FSM SHALL return to IDLE, op_count SHALL increment (wrapping at 2^CNT_W), and err_count SHALL increment if rsp_err is set, saturating at 255.
REQ-026 Latency SHALL be: accept at edge t, rsp_valid high after edge t+2; the next acceptance is at the earliest one cycle after the response handshake.
REQ-027 rsp_ready at a port without rsp_valid, and req_valid changes outside IDLE, SHALL have no effect.

Reset
REQ-028 While rst_n is low at a clock edge, the block SHALL enter IDLE, set last_grant = 1 (port 0 wins first), and clear rsp_valid, req_ready, all response registers, op_count and err_count.
REQ-029 A reset asserted during EXEC or RESP SHALL drop the in-flight transaction without a response and without counting it.

Structure
REQ-030 The opcode enum, FSM state enum, and port-count constant SHALL live in the shared package alu_pkg.
REQ-031 The combinational ALU (operands, opcode -> result, flags, err) SHALL be a single sub-module alu_core, instantiated once and shared by both ports.

Verification
REQ-032 Port 0 sends ADD a=32'h7FFFFFFF, b=1 -> rsp_valid[0] two cycles after acceptance; result 32'h80000000; n=1, v=1, c=0, z=0.
REQ-033 Both ports valid in the same cycle after reset (port 0 SUB 5-5, port 1 AND) -> port 0 is served first with z=1, c=1; port 1 is served next; on the third contention port 0 wins again.
REQ-034 Port 1 sends op 4'b1111 -> rsp_err=1, result 0, err_count=1, op_count=1.
REQ-035 SRA a=32'h80000000, b=31 -> result 32'hFFFFFFFF; SLTU a=1, b=32'hFFFFFFFF -> result 1.
REQ-036 rsp_ready held low for 5 cycles in RESP -> response stays stable, req_ready stays 0 for both ports, busy=1.
REQ-037 rst_n low for one cycle during RESP -> rsp_valid 0 next cycle, counters 0, and the next contention is granted to port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM states
// and the number of requesting ports.
package alu_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU shared by both request ports.
// Illegal opcodes produce a zero result with every flag cleared and err set.
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        n,
  output logic        z,
  output logic        v,
  output logic        c,
  output logic        err
);

  logic [32:0] sum_w;
  logic [32:0] diff_w;

  // Subtraction is done as a + ~b + 1 so bit 32 is directly the not-borrow flag.
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} + {1'b0, ~b} + 33'd1;

  // Select the operation result and derive flags; z is suppressed for illegal ops.
  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_w[31:0];
        c      = sum_w[32];
        v      = (a[31] == b[31]) && (sum_w[31] != a[31]);
      end
      OP_SUB: begin
        result = diff_w[31:0];
        c      = diff_w[32];
        v      = (a[31] != b[31]) && (diff_w[31] != a[31]);
      end
      OP_SLL:  result = a << b[4:0];
      OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: result = {31'd0, a < b};
      OP_XOR:  result = a ^ b;
      OP_SRL:  result = a >> b[4:0];
      OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: err = 1'b1;
    endcase
    n = result[31];
    z = !err && (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end to a single shared ALU. One transaction
// is in flight at a time: accept in IDLE, compute in EXEC, hold the
// response in RESP until the requesting port consumes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [31:0]          req_a0,
  input  logic [31:0]          req_b0,
  input  logic [31:0]          req_a1,
  input  logic [31:0]          req_b1,
  input  logic [3:0]           req_op0,
  input  logic [3:0]           req_op1,
  output logic [NUM_PORTS-1:0] rsp_valid,
  input  logic [NUM_PORTS-1:0] rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 rsp_n,
  output logic                 rsp_z,
  output logic                 rsp_v,
  output logic                 rsp_c,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count,
  output logic [7:0]           err_count
);

  arb_state_e  state;
  logic        last_grant;
  logic        grant_port;
  logic        lat_port;
  logic [31:0] lat_a;
  logic [31:0] lat_b;
  logic [3:0]  lat_op;
  logic [31:0] alu_result;
  logic        alu_n;
  logic        alu_z;
  logic        alu_v;
  logic        alu_c;
  logic        alu_err;

  assign busy = (state != IDLE);

  alu_core u_alu (
    .a      (lat_a),
    .b      (lat_b),
    .op     (lat_op),
    .result (alu_result),
    .n      (alu_n),
    .z      (alu_z),
    .v      (alu_v),
    .c      (alu_c),
    .err    (alu_err)
  );

  // Round-robin pick and IDLE-only ready; held low while reset is asserted.
  always_comb begin
    grant_port = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      grant_port = ~last_grant;
    end else if (req_valid[1]) begin
      grant_port = 1'b1;
    end
    req_ready = '0;
    if (rst_n && (state == IDLE)) begin
      req_ready[grant_port] = req_valid[grant_port];
    end
  end

  // Transaction FSM: latch request, register ALU output, then present and count the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_port   <= 1'b0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_n      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_c      <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            lat_a      <= grant_port ? req_a1  : req_a0;
            lat_b      <= grant_port ? req_b1  : req_b0;
            lat_op     <= grant_port ? req_op1 : req_op0;
            lat_port   <= grant_port;
            last_grant <= grant_port;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_n      <= alu_n;
          rsp_z      <= alu_z;
          rsp_v      <= alu_v;
          rsp_c      <= alu_c;
          rsp_err    <= alu_err;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_valid[lat_port] && rsp_ready[lat_port]) begin
            rsp_valid <= '0;
            op_count  <= op_count + 1'b1;
            if (rsp_err && (err_count != 8'hFF)) begin
              err_count <= err_count + 1'b1;
            end
            state <= IDLE;
          end else begin
            rsp_valid[lat_port] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
